gp_regfile_2r1w: RTL
====================

// Module: gp_regfile_2r1w
// PURPOSE
//  Parametrised successor to the 16x32 general-purpose register bank: NUM_REGS x DATA_W, one write port, two read ports (A, B).
//  Keeps the one-hot control-vector interface (GRin / GRoutA / GRoutB) and encodes it internally.
//  Adds three things: a multi-cycle sequential clear sweep with a busy handshake, sticky one-hot violation detection,
//  and optional write-through bypass.
//  Sits between the datapath bus and the ALU operand buses; driven by the control unit.
// PARAMETERS
//  DATA_W    32     register width in bits
//  NUM_REGS  16     register count, 2..64
//  ADDR_W    $clog2(NUM_REGS)   encoded index width (derived localparam, not overridable)
//  CLR_VAL   '0     value loaded by reset and by the clear sweep (DATA_W bits)
// PORTS
//  clk        in   1         rising-edge clock
//  reset      in   1         asynchronous, active-high reset
//  bus_in     in   DATA_W    write data from BusMuxOut
//  GRin       in   NUM_REGS  one-hot write enable (register perspective)
//  GRoutA     in   NUM_REGS  one-hot read select, port A
//  GRoutB     in   NUM_REGS  one-hot read select, port B
//  BAout      in   1         base-address mode: R0 reads as zero on either port
//  clr_req    in   1         start clear sweep (sampled in IDLE only)
//  rd_a       out  DATA_W    port A read data (combinational)
//  rd_b       out  DATA_W    port B read data (combinational)
//  clr_busy   out  1         high while the sweep is in progress
//  onehot_err out  1         sticky; set on any multi-hot control vector
// BEHAVIOUR
//  Reset (async): all registers = CLR_VAL; FSM = IDLE; sweep index = 0; clr_busy = 0; onehot_err = 0.
//  Write: on a clk edge with exactly one GRin bit set and FSM = IDLE, reg[idx] <= bus_in. All-zero GRin: no write.
//  Read: rd_x = reg[idx(GRoutX)], combinational. All-zero select -> rd_x = 0.
//    GRoutX[0] && BAout -> rd_x = 0. Port A and port B are independent; both may select the same register.
//  Multi-hot:
//    GRin with >1 bit set -> no write that cycle.
//    GRoutX with >1 bit set -> rd_x = 0.
//    Either case sets onehot_err at the next edge; only reset clears it.
//  Clear FSM (IDLE, SWEEP):
//    IDLE: clr_req = 1 -> SWEEP; index <= 0; clr_busy rises the following cycle (registered).
//    SWEEP: one register per cycle, reg[index] <= CLR_VAL; index++.
//      When index = NUM_REGS-1 -> IDLE; clr_busy = 0 the cycle after the last write.
//      Total: NUM_REGS busy cycles.
//    During SWEEP:
//      GRin writes are dropped (the controller must stall on clr_busy).
//      clr_req is ignored.
//      Reads stay live; a register returns its old value until its index has been swept.
//  Reset mid-sweep: immediate return to IDLE; all registers = CLR_VAL.
//  Simultaneous clr_req and a GRin write in IDLE: the write is performed, and the sweep starts next cycle
//    (so it clears that write).
// CONFIGURATION
//  REGFILE_BYPASS_EN defined:
//    A read whose index equals the index being written this cycle (valid one-hot GRin, IDLE) returns bus_in.
//    The BAout R0 rule still takes precedence.
//  Not defined: reads return the stored value; the new data is visible the cycle after the edge.
// STRUCTURE
//  Package gp_regfile_pkg:
//    typedef enum {IDLE, SWEEP} clr_state_t;
//    function is_onehot_or_zero(vector);
//    localparam ADDR_W derivation helper.
//  Sub-module onehot_enc #(N): N-bit one-hot -> $clog2(N) index plus valid and multi flags.
//    Instantiated three times (GRin, GRoutA, GRoutB).
//  Storage: flop array with async reset (no RAM inference; async reset is required).
// TESTING
//  1. Write 0xDEADBEEF with GRin=1<<5, then GRoutA=1<<5 -> rd_a=0xDEADBEEF next cycle; rd_b (GRoutB=0) = 0.
//  2. R0 holds 0x1234, BAout=1, GRoutA=1, GRoutB=1<<0 -> rd_a=rd_b=0. With BAout=0, both ports = 0x1234.
//  3. Fill all regs, pulse clr_req -> clr_busy high for exactly NUM_REGS cycles.
//     A GRin write to R3 mid-sweep is dropped; afterwards every reg = CLR_VAL.
//  4. GRin=0x0003 with bus_in=0xFFFF -> R0 and R1 unchanged; onehot_err=1 and stays 1 until reset.
//  5. Assert reset at sweep cycle 4 -> clr_busy=0 at once, all regs=CLR_VAL; a new clr_req is accepted.
//  6. Bypass: GRin=GRoutA=1<<7, bus_in=0xA5A5A5A5 in the same cycle.
//     Macro defined -> rd_a=0xA5A5A5A5 that cycle. Undefined -> rd_a shows the old R7 value.

Source files
------------

// File: rtl/gp_regfile_pkg.sv
// Shared types and helpers for the gp_regfile_2r1w register bank.
package gp_regfile_pkg;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        SWEEP = 1'b1
    } clr_state_t;

    localparam int unsigned MAX_REGS = 64;

    // Encoded index width; a 2-entry bank still needs one index bit.
    function automatic int unsigned addr_w_of(input int unsigned n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

    function automatic logic is_onehot_or_zero(input logic [MAX_REGS-1:0] vec);
        return (vec & (vec - MAX_REGS'(1))) == '0;
    endfunction

endpackage

// File: rtl/onehot_enc.sv
// One-hot to binary index encoder with valid (exactly one bit) and multi (>1 bit) flags.
module onehot_enc
    import gp_regfile_pkg::*;
#(
    parameter int unsigned N = 16
) (
    input  logic [N-1:0]             i_vec,
    output logic [addr_w_of(N)-1:0]  o_idx,
    output logic                     o_valid,
    output logic                     o_multi
);

    localparam int unsigned AW = addr_w_of(N);

    // OR-reduction of set-bit positions; only meaningful when o_valid.
    always_comb begin
        o_idx = '0;
        for (int i = 0; i < int'(N); i++) begin
            if (i_vec[i]) begin
                o_idx = o_idx | AW'(i);
            end
        end
    end

    assign o_multi = !is_onehot_or_zero(MAX_REGS'(i_vec));
    assign o_valid = (|i_vec) && !o_multi;

endmodule

// File: rtl/gp_regfile_2r1w.sv
// NUM_REGS x DATA_W register bank, one-hot controlled, 1 write / 2 read ports, clear sweep.
// Optional write-through bypass when REGFILE_BYPASS_EN is defined.
module gp_regfile_2r1w
    import gp_regfile_pkg::*;
#(
    parameter int unsigned       DATA_W   = 32,
    parameter int unsigned       NUM_REGS = 16,
    parameter logic [DATA_W-1:0] CLR_VAL  = '0
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [DATA_W-1:0]   bus_in,
    input  logic [NUM_REGS-1:0] GRin,
    input  logic [NUM_REGS-1:0] GRoutA,
    input  logic [NUM_REGS-1:0] GRoutB,
    input  logic                BAout,
    input  logic                clr_req,
    output logic [DATA_W-1:0]   rd_a,
    output logic [DATA_W-1:0]   rd_b,
    output logic                clr_busy,
    output logic                onehot_err
);

    localparam int unsigned ADDR_W = addr_w_of(NUM_REGS);

    logic [DATA_W-1:0] r_regs [NUM_REGS];
    clr_state_t        r_state;
    clr_state_t        w_state_nxt;
    logic [ADDR_W-1:0] r_idx;
    logic [ADDR_W-1:0] w_idx_nxt;
    logic              r_busy;
    logic              w_busy_nxt;
    logic              r_err;

    logic [ADDR_W-1:0] w_wr_idx, w_a_idx, w_b_idx;
    logic              w_wr_valid, w_a_valid, w_b_valid;
    logic              w_wr_multi, w_a_multi, w_b_multi;
    logic              w_we;

    onehot_enc #(.N(NUM_REGS)) u_enc_wr (
        .i_vec(GRin), .o_idx(w_wr_idx), .o_valid(w_wr_valid), .o_multi(w_wr_multi)
    );
    onehot_enc #(.N(NUM_REGS)) u_enc_a (
        .i_vec(GRoutA), .o_idx(w_a_idx), .o_valid(w_a_valid), .o_multi(w_a_multi)
    );
    onehot_enc #(.N(NUM_REGS)) u_enc_b (
        .i_vec(GRoutB), .o_idx(w_b_idx), .o_valid(w_b_valid), .o_multi(w_b_multi)
    );

    assign w_we = (r_state == IDLE) && w_wr_valid;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= IDLE;
            r_idx   <= '0;
            r_busy  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_idx   <= w_idx_nxt;
            r_busy  <= w_busy_nxt;
        end
    end

    // Clear sweep sequencing: one register per cycle, NUM_REGS busy cycles.
    always_comb begin
        w_state_nxt = r_state;
        w_idx_nxt   = r_idx;
        w_busy_nxt  = r_busy;
        case (r_state)
            IDLE: begin
                if (clr_req) begin
                    w_state_nxt = SWEEP;
                    w_idx_nxt   = '0;
                    w_busy_nxt  = 1'b1;
                end
            end
            SWEEP: begin
                w_idx_nxt = r_idx + ADDR_W'(1);
                if (r_idx == ADDR_W'(NUM_REGS - 1)) begin
                    w_state_nxt = IDLE;
                    w_idx_nxt   = '0;
                    w_busy_nxt  = 1'b0;
                end
            end
            default: begin
                w_state_nxt = IDLE;
                w_busy_nxt  = 1'b0;
            end
        endcase
    end

    // Storage: sweep clears take priority; bus writes only land while idle.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < int'(NUM_REGS); i++) begin
                r_regs[i] <= CLR_VAL;
            end
        end else begin
            for (int i = 0; i < int'(NUM_REGS); i++) begin
                if (r_state == SWEEP) begin
                    if (r_idx == ADDR_W'(i)) begin
                        r_regs[i] <= CLR_VAL;
                    end
                end else if (w_we && (w_wr_idx == ADDR_W'(i))) begin
                    r_regs[i] <= bus_in;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_err <= 1'b0;
        end else begin
            r_err <= r_err | w_wr_multi | w_a_multi | w_b_multi;
        end
    end

    always_comb begin
        rd_a = '0;
        if (w_a_valid && !(BAout && GRoutA[0])) begin
            rd_a = r_regs[w_a_idx];
`ifdef REGFILE_BYPASS_EN
            if (w_we && (w_wr_idx == w_a_idx)) begin
                rd_a = bus_in;
            end
`endif
        end
    end

    always_comb begin
        rd_b = '0;
        if (w_b_valid && !(BAout && GRoutB[0])) begin
            rd_b = r_regs[w_b_idx];
`ifdef REGFILE_BYPASS_EN
            if (w_we && (w_wr_idx == w_b_idx)) begin
                rd_b = bus_in;
            end
`endif
        end
    end

    assign clr_busy   = r_busy;
    assign onehot_err = r_err;

endmodule
